game_state_decoder: RTL and testbench
=====================================

# game_state_decoder

Receiving end of the 3-bit game-state bus driven by the game state encoder. Registers the state code and turns it into one-hot phase flags, a one-cycle state-entry pulse, the 3-2-1 countdown digit, a "GO" banner flag, a pause-blink signal and a pause-aware race timer (seconds plus centiseconds). Display, audio and physics blocks consume its outputs instead of decoding `state` themselves.

## Interface
- `SECOND`, 100000000: clk cycles per second.
- `TICK_DIV`, SECOND/100: clk cycles per centisecond tick.
- `BLINK_HALF`, SECOND/4: clk cycles per half-period of the pause blink.
- `clk` in 1: system clock.
- `rst` in 1: reset, synchronous, active-high.
- `state` in 3: state code. 0 IDLE, 1 SETTING, 3 COUNTDOWN, 4 RACING, 5 PAUSE, 6 FINISH. Codes 2 and 7 are invalid.
- `in_idle`, `in_setting`, `in_countdown`, `in_racing`, `in_paused`, `in_finish` out 1 each: one-hot phase flags.
- `bad_state` out 1: the sampled code is 2 or 7.
- `state_entry` out 1: one-cycle pulse when the sampled code changes.
- `cd_digit` out 2: countdown digit 3/2/1. Reads 0 outside COUNTDOWN.
- `go_flag` out 1: "GO" banner for the first second of RACING.
- `blink` out 1: pause blink.
- `race_sec` out 10: elapsed race seconds, 0–999.
- `race_cs` out 7: elapsed centiseconds, 0–99.
- `time_sat` out 1: race timer saturated.

## Operation
- Sampling: each cycle `state_q <= state`. All outputs are registered and computed from the incoming `state` and the current `state_q`.
- Flags: exactly one `in_*` is high for a valid code. For code 2 or 7, all `in_*` are low, `bad_state` is 1, and every counter holds.
- Entry: `state_entry` is 1 in the cycle the flags change.
  - A fresh start is entry into COUNTDOWN from any state other than PAUSE.
  - A resume is entry from PAUSE into COUNTDOWN or RACING.
- Countdown:
  - On a fresh start: `cd_digit` = 3, prescaler = 0, race timer and `time_sat` cleared.
  - While in COUNTDOWN, the prescaler counts to SECOND-1, then wraps and decrements `cd_digit`. The digit never goes below 1.
  - On a resume into COUNTDOWN, digit and prescaler continue from their held values.
- GO: `go_flag` is set on entry into RACING from COUNTDOWN, and its counter starts at 0.
  - Clears after SECOND cycles in RACING, or on leaving RACING.
  - During PAUSE its counter holds and the flag is forced to 0. On resume the flag is restored if the counter has not yet expired.
- Race timer:
  - Advances only while in RACING. The prescaler counts 0..TICK_DIV-1; at wrap, `race_cs` increments.
  - When `race_cs` wraps 99→0, `race_sec` increments.
  - In PAUSE, FINISH, IDLE and SETTING the prescaler and the value hold, so pause time is excluded exactly.
  - At 999.99 the timer stops, `time_sat` goes to 1, and both stay until the next fresh start.
- Blink: on entry into PAUSE, `blink` = 1 and its counter = 0. `blink` toggles every BLINK_HALF cycles while paused and is 0 outside PAUSE.
- Counter widths use $clog2 of the respective parameter. There is no overflow other than the defined wraps.

## Timing
- Reset values: `state_q` = IDLE, `in_idle` = 1, all other outputs 0, all counters 0.
- Latency: `state` change at edge N is reflected on flags, `state_entry` and reset counters after edge N+1 (1 cycle).
- Counter updates in the entry cycle use the new state: first race tick TICK_DIV cycles after `in_racing` rises.
- Simultaneous saturation and leaving RACING: saturation wins for `time_sat`; the value holds at 999.99.
- `rst` mid-race returns every output to its reset value on the next edge. No timer state survives.
- Back-to-back code changes on consecutive cycles produce a `state_entry` pulse each cycle.

## Configuration
- `GAME_STATE_DECODER_BLINK_EN`:
  - Defined: `blink` behaves as specified above.
  - Undefined: the blink counter is not built and `blink` = `in_paused` (steady 1 while paused).

## Test plan
Sim parameters: SECOND=20, TICK_DIV=2, BLINK_HALF=5.
- Reset with `state`=0 → next cycle `in_idle`=1, all other outputs 0, `race_sec`=0, `race_cs`=0.
- IDLE→COUNTDOWN held 60 cycles → `state_entry` pulse 1 cycle after change. `cd_digit` is 3 for 20 cycles, then 2 for 20 cycles, then 1 for 20 cycles.
- COUNTDOWN→RACING held 30 cycles → `go_flag`=1 for exactly 20 cycles, then 0. Timer reads `race_sec`=0, `race_cs`=15.
- RACING 10 cycles, PAUSE 23 cycles, RACING 10 cycles:
  - Timer reads `race_cs`=10, with no advance in PAUSE.
  - `blink` pattern during PAUSE is 1×5, 0×5, 1×5, 0×5, 1×3.
  - With the macro undefined, `blink`=1 for all 23 cycles.
- Force timer to 999.98 in RACING for 10 cycles → stops at 999.99 with `time_sat`=1. A fresh COUNTDOWN entry clears both to 0.
- `state`=7 for 5 cycles mid-race → `bad_state`=1, all `in_*`=0, timer frozen. Returning to 4 resumes counting from the frozen value.

Source files
------------

// File: rtl/game_state_decoder.sv
`default_nettype none
// ============================================================================
// Module   : game_state_decoder
// Brief    : Decodes the game-state bus into phase flags, countdown digit,
//            GO banner, pause blink and a pause-aware race timer.
//            Define GAME_STATE_DECODER_BLINK_EN to build the blinking pause
//            indicator; otherwise blink is a steady copy of in_paused.
// Revision : 1.0 - initial release
// ============================================================================
module game_state_decoder #(
  parameter int SECOND     = 100000000,
  parameter int TICK_DIV   = SECOND / 100,
  parameter int BLINK_HALF = SECOND / 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] state,
  output logic       in_idle,
  output logic       in_setting,
  output logic       in_countdown,
  output logic       in_racing,
  output logic       in_paused,
  output logic       in_finish,
  output logic       bad_state,
  output logic       state_entry,
  output logic [1:0] cd_digit,
  output logic       go_flag,
  output logic       blink,
  output logic [9:0] race_sec,
  output logic [6:0] race_cs,
  output logic       time_sat
);

  localparam logic [2:0] c_st_idle      = 3'd0;
  localparam logic [2:0] c_st_setting   = 3'd1;
  localparam logic [2:0] c_st_countdown = 3'd3;
  localparam logic [2:0] c_st_racing    = 3'd4;
  localparam logic [2:0] c_st_pause     = 3'd5;
  localparam logic [2:0] c_st_finish    = 3'd6;

  localparam int c_sec_w  = (SECOND > 1) ? $clog2(SECOND) : 1;
  localparam int c_tick_w = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [c_sec_w-1:0]  c_sec_last  = c_sec_w'(SECOND - 1);
  localparam logic [c_tick_w-1:0] c_tick_last = c_tick_w'(TICK_DIV - 1);

  logic [2:0]          state_q;
  logic [5:0]          flags_q, flags_d;
  logic                bad_q, bad_d;
  logic                entry_q, entry_d;
  logic [1:0]          cd_digit_q, cd_digit_d;
  logic [1:0]          cd_cnt_q, cd_cnt_d;
  logic [c_sec_w-1:0]  cd_pre_q, cd_pre_d;
  logic                go_flag_q, go_flag_d;
  logic                go_live_q, go_live_d;
  logic [c_sec_w-1:0]  go_cnt_q, go_cnt_d;
  logic                blink_q, blink_d;
  logic [c_tick_w-1:0] tick_q, tick_d;
  logic [9:0]          race_sec_q, race_sec_d;
  logic [6:0]          race_cs_q, race_cs_d;
  logic                time_sat_q, time_sat_d;

  logic is_cd, is_race, is_pause, is_bad, code_change, fresh_start, go_start;

  assign is_cd       = (state == c_st_countdown);
  assign is_race     = (state == c_st_racing);
  assign is_pause    = (state == c_st_pause);
  assign is_bad      = (state == 3'd2) || (state == 3'd7);
  assign code_change = (state != state_q);
  assign fresh_start = code_change && is_cd && (state_q != c_st_pause);
  assign go_start    = code_change && is_race && (state_q == c_st_countdown);

  always_comb begin
    case (state)
      c_st_idle:      flags_d = 6'b100000;
      c_st_setting:   flags_d = 6'b010000;
      c_st_countdown: flags_d = 6'b001000;
      c_st_racing:    flags_d = 6'b000100;
      c_st_pause:     flags_d = 6'b000010;
      c_st_finish:    flags_d = 6'b000001;
      default:        flags_d = 6'b000000;
    endcase
    bad_d   = is_bad;
    entry_d = code_change;

    // Countdown digit and its prescaler hold outside COUNTDOWN so a resume continues.
    cd_cnt_d = cd_cnt_q;
    cd_pre_d = cd_pre_q;
    if (fresh_start) begin
      cd_cnt_d = 2'd3;
      cd_pre_d = '0;
    end else if (is_cd) begin
      if (cd_pre_q == c_sec_last) begin
        cd_pre_d = '0;
        if (cd_cnt_q > 2'd1) cd_cnt_d = cd_cnt_q - 2'd1;
      end else begin
        cd_pre_d = cd_pre_q + 1'b1;
      end
    end
    cd_digit_d = is_cd ? cd_cnt_d : 2'd0;

    go_cnt_d  = go_cnt_q;
    go_live_d = go_live_q;
    if (go_start) begin
      go_cnt_d  = '0;
      go_live_d = 1'b1;
    end else if (is_race) begin
      if (go_live_q) begin
        if (go_cnt_q == c_sec_last) go_live_d = 1'b0;
        else                        go_cnt_d  = go_cnt_q + 1'b1;
      end
    end else if (!is_pause && !is_bad) begin
      go_live_d = 1'b0;
    end
    go_flag_d = is_race && go_live_d;

    tick_d     = tick_q;
    race_cs_d  = race_cs_q;
    race_sec_d = race_sec_q;
    time_sat_d = time_sat_q;
    if (fresh_start) begin
      tick_d     = '0;
      race_cs_d  = '0;
      race_sec_d = '0;
      time_sat_d = 1'b0;
    end else if (is_race && !time_sat_q) begin
      if (tick_q == c_tick_last) begin
        tick_d = '0;
        if (race_cs_q == 7'd99) begin
          race_cs_d  = '0;
          race_sec_d = race_sec_q + 10'd1;
        end else begin
          race_cs_d = race_cs_q + 7'd1;
        end
      end else begin
        tick_d = tick_q + 1'b1;
      end
      if ((race_sec_d == 10'd999) && (race_cs_d == 7'd99)) time_sat_d = 1'b1;
    end
  end

`ifdef GAME_STATE_DECODER_BLINK_EN
  localparam int c_blink_w = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [c_blink_w-1:0] c_blink_last = c_blink_w'(BLINK_HALF - 1);

  logic                 blink_st_q, blink_st_d;
  logic [c_blink_w-1:0] blink_cnt_q, blink_cnt_d;

  always_comb begin
    blink_st_d  = blink_st_q;
    blink_cnt_d = blink_cnt_q;
    if (is_pause && code_change) begin
      blink_st_d  = 1'b1;
      blink_cnt_d = '0;
    end else if (is_pause) begin
      if (blink_cnt_q == c_blink_last) begin
        blink_cnt_d = '0;
        blink_st_d  = ~blink_st_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      blink_st_q  <= 1'b0;
      blink_cnt_q <= '0;
    end else begin
      blink_st_q  <= blink_st_d;
      blink_cnt_q <= blink_cnt_d;
    end
  end

  assign blink_d = is_pause && blink_st_d;
`else
  // A non-positive half-period leaves the indicator dark.
  if (BLINK_HALF > 0) begin : g_blink_steady
    assign blink_d = is_pause;
  end else begin : g_blink_off
    assign blink_d = 1'b0;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= c_st_idle;
      flags_q    <= 6'b100000;
      bad_q      <= 1'b0;
      entry_q    <= 1'b0;
      cd_digit_q <= 2'd0;
      cd_cnt_q   <= 2'd0;
      cd_pre_q   <= '0;
      go_flag_q  <= 1'b0;
      go_live_q  <= 1'b0;
      go_cnt_q   <= '0;
      blink_q    <= 1'b0;
      tick_q     <= '0;
      race_sec_q <= '0;
      race_cs_q  <= '0;
      time_sat_q <= 1'b0;
    end else begin
      state_q    <= state;
      flags_q    <= flags_d;
      bad_q      <= bad_d;
      entry_q    <= entry_d;
      cd_digit_q <= cd_digit_d;
      cd_cnt_q   <= cd_cnt_d;
      cd_pre_q   <= cd_pre_d;
      go_flag_q  <= go_flag_d;
      go_live_q  <= go_live_d;
      go_cnt_q   <= go_cnt_d;
      blink_q    <= blink_d;
      tick_q     <= tick_d;
      race_sec_q <= race_sec_d;
      race_cs_q  <= race_cs_d;
      time_sat_q <= time_sat_d;
    end
  end

  assign {in_idle, in_setting, in_countdown, in_racing, in_paused, in_finish} = flags_q;
  assign bad_state   = bad_q;
  assign state_entry = entry_q;
  assign cd_digit    = cd_digit_q;
  assign go_flag     = go_flag_q;
  assign blink       = blink_q;
  assign race_sec    = race_sec_q;
  assign race_cs     = race_cs_q;
  assign time_sat    = time_sat_q;

endmodule
`default_nettype wire

// File: tb/tb_game_state_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_game_state_decoder
// Brief    : Directed-vector scoreboard bench for game_state_decoder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_game_state_decoder;

  localparam int SECOND     = 20;
  localparam int TICK_DIV   = 2;
  localparam int BLINK_HALF = 5;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] state;
  logic       in_idle, in_setting, in_countdown, in_racing, in_paused, in_finish;
  logic       bad_state, state_entry, go_flag, blink, time_sat;
  logic [1:0] cd_digit;
  logic [9:0] race_sec;
  logic [6:0] race_cs;

  typedef struct packed {
    logic [5:0] flags;
    logic       bad;
    logic       entry;
    logic [1:0] cd;
    logic       go;
    logic       bl;
    logic [9:0] sec;
    logic [6:0] cs;
    logic       sat;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  exp_t  got, m_e;
  string m_n;
  int    checks = 0;
  int    fails  = 0;

  game_state_decoder #(
    .SECOND     (SECOND),
    .TICK_DIV   (TICK_DIV),
    .BLINK_HALF (BLINK_HALF)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .state        (state),
    .in_idle      (in_idle),
    .in_setting   (in_setting),
    .in_countdown (in_countdown),
    .in_racing    (in_racing),
    .in_paused    (in_paused),
    .in_finish    (in_finish),
    .bad_state    (bad_state),
    .state_entry  (state_entry),
    .cd_digit     (cd_digit),
    .go_flag      (go_flag),
    .blink        (blink),
    .race_sec     (race_sec),
    .race_cs      (race_cs),
    .time_sat     (time_sat)
  );

  always #5 clk = ~clk;

  assign got = {in_idle, in_setting, in_countdown, in_racing, in_paused, in_finish,
                bad_state, state_entry, cd_digit, go_flag, blink, race_sec, race_cs, time_sat};

  function automatic logic [5:0] fl(input logic [2:0] c);
    case (c)
      3'd0:    return 6'b100000;
      3'd1:    return 6'b010000;
      3'd3:    return 6'b001000;
      3'd4:    return 6'b000100;
      3'd5:    return 6'b000010;
      3'd6:    return 6'b000001;
      default: return 6'b000000;
    endcase
  endfunction

  function automatic exp_t mk(input logic [2:0] c, input logic en, input logic [1:0] cd,
                              input logic go, input logic bl, input int sec, input int cs,
                              input logic sat);
    exp_t e;
    e.flags = fl(c);
    e.bad   = (c == 3'd2) || (c == 3'd7);
    e.entry = en;
    e.cd    = cd;
    e.go    = go;
    e.bl    = bl;
    e.sec   = 10'(sec);
    e.cs    = 7'(cs);
    e.sat   = sat;
    return e;
  endfunction

  task automatic step(input logic r, input logic [2:0] c, input exp_t e, input string nm);
    @(negedge clk);
    rst   = r;
    state = c;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // Monitor: every clock the DUT presents a full output word; check it against the queue head.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() != 0) begin
      m_e = exp_q.pop_front();
      m_n = name_q.pop_front();
      checks++;
      if (got !== m_e) begin
        fails++;
        $display("FAIL %s: got flags=%b bad=%b entry=%b cd=%0d go=%b blink=%b sec=%0d cs=%0d sat=%b, expected flags=%b bad=%b entry=%b cd=%0d go=%b blink=%b sec=%0d cs=%0d sat=%b",
                 m_n, got.flags, got.bad, got.entry, got.cd, got.go, got.bl, got.sec, got.cs, got.sat,
                 m_e.flags, m_e.bad, m_e.entry, m_e.cd, m_e.go, m_e.bl, m_e.sec, m_e.cs, m_e.sat);
      end
    end
  end

  initial begin
    logic bl;
    rst   = 1'b1;
    state = 3'd0;

    for (int i = 0; i < 2; i++) step(1'b1, 3'd0, mk(3'd0, 1'b0, 2'd0, 1'b0, 1'b0, 0, 0, 1'b0), "reset");
    for (int i = 0; i < 3; i++) step(1'b0, 3'd0, mk(3'd0, 1'b0, 2'd0, 1'b0, 1'b0, 0, 0, 1'b0), "idle");

    for (int i = 0; i < 60; i++)
      step(1'b0, 3'd3, mk(3'd3, i == 0, 2'(3 - i / 20), 1'b0, 1'b0, 0, 0, 1'b0), "countdown");

    for (int i = 0; i < 30; i++)
      step(1'b0, 3'd4, mk(3'd4, i == 0, 2'd0, i < 20, 1'b0, 0, (i + 1) / 2, 1'b0), "race_go");

    for (int i = 0; i < 2; i++)
      step(1'b0, 3'd6, mk(3'd6, i == 0, 2'd0, 1'b0, 1'b0, 0, 15, 1'b0), "finish_hold");

    for (int i = 0; i < 2; i++)
      step(1'b0, 3'd3, mk(3'd3, i == 0, 2'd3, 1'b0, 1'b0, 0, 0, 1'b0), "fresh_start");

    for (int i = 0; i < 10; i++)
      step(1'b0, 3'd4, mk(3'd4, i == 0, 2'd0, 1'b1, 1'b0, 0, (i + 1) / 2, 1'b0), "race_a");

    for (int i = 0; i < 23; i++) begin
`ifdef GAME_STATE_DECODER_BLINK_EN
      bl = ((i / 5) % 2) == 0;
`else
      bl = 1'b1;
`endif
      step(1'b0, 3'd5, mk(3'd5, i == 0, 2'd0, 1'b0, bl, 0, 5, 1'b0), "pause");
    end

    // GO resumes after the pause and expires after 20 racing cycles in total.
    for (int i = 0; i < 12; i++)
      step(1'b0, 3'd4, mk(3'd4, i == 0, 2'd0, i < 10, 1'b0, 0, 5 + (i + 1) / 2, 1'b0), "race_b");

    for (int i = 0; i < 5; i++)
      step(1'b0, 3'd7, mk(3'd7, i == 0, 2'd0, 1'b0, 1'b0, 0, 11, 1'b0), "bad_code");

    for (int i = 0; i < 4; i++)
      step(1'b0, 3'd4, mk(3'd4, i == 0, 2'd0, 1'b0, 1'b0, 0, 11 + (i + 1) / 2, 1'b0), "race_resume");

    step(1'b0, 3'd6, mk(3'd6, 1'b1, 2'd0, 1'b0, 1'b0, 0, 13, 1'b0), "finish");

    // Load 999.98 into the timer while it holds in FINISH.
    @(negedge clk);
    state = 3'd6;
    force dut.race_sec_d = 10'd999;
    force dut.race_cs_d  = 7'd98;
    exp_q.push_back(mk(3'd6, 1'b0, 2'd0, 1'b0, 1'b0, 999, 98, 1'b0));
    name_q.push_back("timer_load");
    @(posedge clk);
    #2;
    release dut.race_sec_d;
    release dut.race_cs_d;

    for (int i = 0; i < 10; i++)
      step(1'b0, 3'd4, mk(3'd4, i == 0, 2'd0, 1'b0, 1'b0, 999, (i == 0) ? 98 : 99, i >= 1), "saturate");

    step(1'b0, 3'd1, mk(3'd1, 1'b1, 2'd0, 1'b0, 1'b0, 999, 99, 1'b1), "b2b_setting");
    step(1'b0, 3'd0, mk(3'd0, 1'b1, 2'd0, 1'b0, 1'b0, 999, 99, 1'b1), "b2b_idle");
    step(1'b0, 3'd3, mk(3'd3, 1'b1, 2'd3, 1'b0, 1'b0, 0, 0, 1'b0), "b2b_fresh");

    for (int i = 0; i < 3; i++)
      step(1'b0, 3'd4, mk(3'd4, i == 0, 2'd0, 1'b1, 1'b0, 0, (i + 1) / 2, 1'b0), "race_c");

    step(1'b1, 3'd4, mk(3'd0, 1'b0, 2'd0, 1'b0, 1'b0, 0, 0, 1'b0), "mid_race_rst");
    step(1'b0, 3'd0, mk(3'd0, 1'b0, 2'd0, 1'b0, 1'b0, 0, 0, 1'b0), "after_rst");

    repeat (3) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
`default_nettype wire
